dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words stored; power of two, 4 to 4096.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted between request acceptance and response; range 0 to 15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator has a request on the req_* signals.
REQ-006 req_ready  output  1  responder accepts a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_be  input  4  byte enables for writes; bit i selects byte i (bits 8i+7:8i).
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator takes the response this cycle.
REQ-013 rsp_rdata  output  32  read data; 0 for writes and for errors.
REQ-014 rsp_err  output  1  request was misaligned or out of range.
REQ-015 txn_count  output  16  count of completed responses; wraps from 0xFFFF to 0.

Function
REQ-016 The block SHALL be a three-state FSM: IDLE, WAIT, RESP.
REQ-017 In IDLE, req_ready = 1. In WAIT and RESP, req_ready = 0. Only one transaction is outstanding at a time.
REQ-018 A request is accepted on a rising edge where state is IDLE and req_valid = 1. On that edge the block latches we, addr, wdata and be.
REQ-019 On acceptance, the FSM SHALL go to WAIT and load the wait counter with WAIT_CYCLES. If WAIT_CYCLES = 0, it SHALL go directly to RESP.
REQ-020 In WAIT, the counter decrements each cycle. When the counter reaches 1, the next state is RESP.
REQ-021 Latency: if acceptance is at edge N, rsp_valid SHALL first be high after edge N+1+WAIT_CYCLES.
REQ-022 Error condition: latched addr[1:0] != 0, or word index addr[31:2] >= DEPTH_WORDS.
REQ-023 The memory access SHALL occur on the edge that enters RESP:
 - Write without error: update only the enabled bytes; rdata = 0.
 - Read without error: rdata = mem[addr[31:2]].
 - Error: memory is not modified; rdata = 0; err = 1.
 - Write with be = 0: memory is unchanged and the transaction completes normally.
REQ-024 In RESP, rsp_valid = 1, and rsp_rdata and rsp_err SHALL stay stable until the handshake.
REQ-025 If rsp_ready = 0, the FSM SHALL stay in RESP indefinitely.
REQ-026 When rsp_valid and rsp_ready are both 1, the FSM SHALL go to IDLE and txn_count SHALL increment by 1. Errored transactions are counted.
REQ-027 A new request is not accepted in the same cycle as the response handshake. The earliest next acceptance is the edge after the return to IDLE.
REQ-028 rsp_valid, rsp_rdata and rsp_err are registered outputs. req_ready is decoded from state only.
REQ-029 Changes on req_* while state is not IDLE SHALL have no effect.

Reset
REQ-030 While reset = 1:
 - state = IDLE
 - wait counter = 0
 - req_ready = 1
 - rsp_valid = 0
 - rsp_rdata = 0
 - rsp_err = 0
 - txn_count = 0
REQ-031 Reset asserted in WAIT or RESP SHALL discard the transaction with no response. If the write edge has not yet occurred, no memory write takes place.
REQ-032 Memory contents are not cleared by reset and SHALL keep their values across reset.
REQ-033 After reset deasserts, the first request is accepted on the first rising edge with req_valid = 1.

Verification
REQ-034 Write then read-back, WAIT_CYCLES = 2:
 - Write addr 0x10, wdata 0xDEADBEEF, be 0xF; then read addr 0x10.
 - Required: rdata 0xDEADBEEF, err 0, rsp_valid 3 cycles after each acceptance, txn_count = 2.
REQ-035 Partial write:
 - Write 0x11223344 to addr 0x20 (be 0xF), then write 0x000000AA with be 0x1, then read addr 0x20.
 - Required: rdata 0x112233AA.
REQ-036 Errors:
 - Read addr 0x3 -> err 1, rdata 0.
 - Write to addr 4*DEPTH_WORDS -> err 1, and a later read of word 0 is unchanged.
 - txn_count increments for both errored transactions.
REQ-037 Backpressure:
 - Hold rsp_ready = 0 for 10 cycles during RESP.
 - Required: rsp_valid stays 1, rdata is stable, req_ready stays 0 while req_valid = 1; completion occurs on the first cycle rsp_ready = 1.
REQ-038 WAIT_CYCLES = 0 build: back-to-back reads with req_valid and rsp_ready held high.
 - Required: rsp_valid 1 cycle after each acceptance; one acceptance every 3 cycles.
REQ-039 Reset mid-WAIT on a write:
 - Assert reset during WAIT of a write of 0x55 to addr 0x8.
 - Required: rsp_valid never asserts, txn_count = 0, a later read of addr 0x8 returns the prior contents.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: valid/ready request in, registered
// response out after WAIT_CYCLES wait states, with byte-enabled writes.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] txn_count
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a[31:2] >> AW) != 30'd0);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    state_t        state_r;
    logic [3:0]    wcnt_r;
    logic          lat_we_r;
    logic [31:0]   lat_addr_r;
    logic [31:0]   lat_wdata_r;
    logic [3:0]    lat_be_r;
    logic          rsp_valid_r;
    logic [31:0]   rsp_rdata_r;
    logic          rsp_err_r;
    logic [15:0]   txn_count_r;
    logic [31:0]   mem_r [DEPTH_WORDS];

    logic          acc_we_s;
    logic [31:0]   acc_addr_s;
    logic [31:0]   acc_wdata_s;
    logic [3:0]    acc_be_s;
    logic          acc_err_s;
    logic [AW-1:0] acc_idx_s;
    logic          go_resp_s;
    logic          mem_we_s;
    logic [31:0]   rd_word_s;
    logic [31:0]   wr_word_s;

    // Access operands and the "entering RESP" strobe; with zero wait states
    // the access happens on the acceptance edge, so live request fields are used.
    always_comb begin
        acc_we_s    = lat_we_r;
        acc_addr_s  = lat_addr_r;
        acc_wdata_s = lat_wdata_r;
        acc_be_s    = lat_be_r;
        go_resp_s   = 1'b0;
        if (state_r == IDLE) begin
            acc_we_s    = req_we;
            acc_addr_s  = req_addr;
            acc_wdata_s = req_wdata;
            acc_be_s    = req_be;
        end else begin
            acc_we_s    = lat_we_r;
            acc_addr_s  = lat_addr_r;
            acc_wdata_s = lat_wdata_r;
            acc_be_s    = lat_be_r;
        end
        case (state_r)
            IDLE:    go_resp_s = req_valid && (WAIT_CYCLES == 0);
            WAIT:    go_resp_s = (wcnt_r <= 4'd1);
            default: go_resp_s = 1'b0;
        endcase
        acc_err_s = addr_err(acc_addr_s);
        acc_idx_s = acc_addr_s[AW+1:2];
        rd_word_s = mem_r[acc_idx_s];
        wr_word_s = merge_bytes(rd_word_s, acc_wdata_s, acc_be_s);
        mem_we_s  = go_resp_s && acc_we_s && !acc_err_s;
    end

    // Storage array: not reset, so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we_s && !reset) begin
            mem_r[acc_idx_s] <= wr_word_s;
        end
    end

    // Control FSM and registered response; rsp_valid rises on the edge after
    // RESP is entered, which yields the N+1+WAIT_CYCLES response latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            wcnt_r      <= 4'd0;
            lat_we_r    <= 1'b0;
            lat_addr_r  <= 32'd0;
            lat_wdata_r <= 32'd0;
            lat_be_r    <= 4'd0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
            txn_count_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        lat_we_r    <= req_we;
                        lat_addr_r  <= req_addr;
                        lat_wdata_r <= req_wdata;
                        lat_be_r    <= req_be;
                        if (WAIT_CYCLES == 0) begin
                            state_r <= RESP;
                        end else begin
                            state_r <= WAIT;
                            wcnt_r  <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wcnt_r <= 4'd1) begin
                        state_r <= RESP;
                    end
                    if (wcnt_r != 4'd0) begin
                        wcnt_r <= wcnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (!rsp_valid_r) begin
                        rsp_valid_r <= 1'b1;
                    end else if (rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 32'd0;
                        rsp_err_r   <= 1'b0;
                        txn_count_r <= txn_count_r + 16'd1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    wcnt_r      <= 4'd0;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= 32'd0;
                    rsp_err_r   <= 1'b0;
                end
            endcase
            if (go_resp_s) begin
                rsp_err_r   <= acc_err_s;
                rsp_rdata_r <= (acc_we_s || acc_err_s) ? 32'd0 : rd_word_s;
            end
        end
    end

    assign req_ready = (state_r == IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign txn_count = txn_count_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance driven by
// directed and random transactions, plus a WAIT_CYCLES=0 instance for streaming.
module tb_dmem_responder;
    localparam int DEPTH  = 64;
    localparam int WAITC  = 2;
    localparam int DEPTH0 = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] txn_count;

    logic        req_valid0 = 1'b0, req_we0 = 1'b0, rsp_ready0 = 1'b1;
    logic [31:0] req_addr0 = 32'd0, req_wdata0 = 32'd0;
    logic [3:0]  req_be0 = 4'd0;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;
    logic [15:0] txn_count0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .txn_count(txn_count)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
        .rsp_err(rsp_err0), .txn_count(txn_count0)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH0];

    // Reference: errors are misaligned or beyond the word count; writes merge enabled bytes.
    task automatic model_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [31:0] rd, output logic err);
        int idx;
        err = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
        rd  = 32'd0;
        if (!err) begin
            idx = int'(addr / 4);
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem_a[idx][8*i +: 8] = wdata[8*i +: 8];
            end else begin
                rd = mem_a[idx];
            end
        end
    endtask

    task automatic model_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [31:0] rd, output logic err);
        int idx;
        err = (addr % 4 != 0) || ((addr / 4) >= DEPTH0);
        rd  = 32'd0;
        if (!err) begin
            idx = int'(addr / 4);
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem_b[idx][8*i +: 8] = wdata[8*i +: 8];
            end else begin
                rd = mem_b[idx];
            end
        end
    endtask

    // Drives one transaction with rsp_ready high; lat counts edges from acceptance to rsp_valid.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [31:0] rd, output logic err,
                           output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_be = 4'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        err = rsp_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        checks++; if (txn_count !== 16'd0) begin failures++; $display("FAIL reset_txn_count got=%0d exp=0", txn_count); end
        checks++; if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0 || txn_count0 !== 16'd0) begin
            failures++; $display("FAIL reset_dut0 got ready=%b valid=%b txn=%0d exp 1/0/0", req_ready0, rsp_valid0, txn_count0);
        end
        reset = 1'b0;
    endtask

    task automatic test_write_readback();
        logic [31:0] rd, erd; logic err, eerr; int lat;
        model_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eerr);
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat);
        checks++; if (lat != WAITC + 1) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, WAITC + 1); end
        checks++; if (rd !== 32'd0 || err !== 1'b0) begin failures++; $display("FAIL wr_rsp got=%h/%b exp=0/0", rd, err); end
        model_a(1'b0, 32'h10, 32'd0, 4'h0, erd, eerr);
        run_txn(1'b0, 32'h10, 32'd0, 4'h0, rd, err, lat);
        checks++; if (lat != WAITC + 1) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", lat, WAITC + 1); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL readback got=%h exp=deadbeef", rd); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL readback_err got=%b exp=0", err); end
        checks++; if (txn_count !== 16'd2) begin failures++; $display("FAIL readback_txn got=%0d exp=2", txn_count); end
    endtask

    task automatic test_partial();
        logic [31:0] rd, erd; logic err, eerr; int lat;
        model_a(1'b1, 32'h20, 32'h11223344, 4'hF, erd, eerr);
        run_txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, err, lat);
        model_a(1'b1, 32'h20, 32'h000000AA, 4'h1, erd, eerr);
        run_txn(1'b1, 32'h20, 32'h000000AA, 4'h1, rd, err, lat);
        model_a(1'b0, 32'h20, 32'd0, 4'h0, erd, eerr);
        run_txn(1'b0, 32'h20, 32'd0, 4'h0, rd, err, lat);
        checks++; if (rd !== 32'h112233AA) begin failures++; $display("FAIL partial got=%h exp=112233aa", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; logic err, eerr; int lat; logic [15:0] t0;
        model_a(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, erd, eerr);
        run_txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, err, lat);
        t0 = txn_count;
        run_txn(1'b0, 32'h3, 32'd0, 4'h0, rd, err, lat);
        checks++; if (err !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL err_misaligned got=%h/%b exp=0/1", rd, err); end
        run_txn(1'b1, 32'(4 * DEPTH), 32'h12345678, 4'hF, rd, err, lat);
        checks++; if (err !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL err_range got=%h/%b exp=0/1", rd, err); end
        run_txn(1'b0, 32'h0, 32'd0, 4'h0, rd, err, lat);
        checks++; if (rd !== 32'hCAFEF00D || err !== 1'b0) begin failures++; $display("FAIL err_word0 got=%h/%b exp=cafef00d/0", rd, err); end
        checks++; if (txn_count !== 16'(t0 + 16'd3)) begin failures++; $display("FAIL err_txn got=%0d exp=%0d", txn_count, t0 + 16'd3); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, erd; logic err, eerr; int lat; logic [15:0] t0;
        t0 = txn_count;
        model_a(1'b0, 32'h10, 32'd0, 4'h0, erd, eerr);
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b1; req_wdata = $urandom; req_be = 4'hF;
        lat = 0;
        while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
        checks++; if (lat != WAITC + 1) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, WAITC + 1); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== erd || req_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold_%0d got valid=%b rdata=%h ready=%b exp 1/%h/0", i, rsp_valid, rsp_rdata, req_ready, erd);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || txn_count !== 16'(t0 + 16'd1)) begin
            failures++; $display("FAIL bp_complete got valid=%b txn=%0d exp 0/%0d", rsp_valid, txn_count, t0 + 16'd1);
        end
        model_a(1'b0, 32'h10, 32'd0, 4'h0, erd, eerr);
        run_txn(1'b0, 32'h10, 32'd0, 4'h0, rd, err, lat);
        checks++; if (rd !== erd) begin failures++; $display("FAIL bp_no_side_write got=%h exp=%h", rd, erd); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd, erd, prior; logic err, eerr; int lat; bit seen;
        prior = $urandom;
        model_a(1'b1, 32'h8, prior, 4'hF, erd, eerr);
        run_txn(1'b1, 32'h8, prior, 4'hF, rd, err, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'h55; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_wait_entered got ready=%b exp=0", req_ready); end
        reset = 1'b1;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        reset = 1'b0;
        repeat (6) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        checks++; if (seen) begin failures++; $display("FAIL rst_no_rsp got=1 exp=0"); end
        checks++; if (txn_count !== 16'd0) begin failures++; $display("FAIL rst_txn got=%0d exp=0", txn_count); end
        model_a(1'b0, 32'h8, 32'd0, 4'h0, erd, eerr);
        run_txn(1'b0, 32'h8, 32'd0, 4'h0, rd, err, lat);
        checks++; if (rd !== prior) begin failures++; $display("FAIL rst_mem_kept got=%h exp=%h", rd, prior); end
        checks++; if (lat != WAITC + 1) begin failures++; $display("FAIL rst_first_accept got=%0d exp=%0d", lat, WAITC + 1); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wdata; logic err, eerr, we; logic [3:0] be; int lat, sel;
        logic [15:0] t0;
        for (int w = 0; w < DEPTH; w++) begin
            wdata = $urandom;
            model_a(1'b1, 32'(w * 4), wdata, 4'hF, erd, eerr);
            run_txn(1'b1, 32'(w * 4), wdata, 4'hF, rd, err, lat);
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL fill_%0d err got=%b exp=0", w, err); end
        end
        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) addr = 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(1, 3));
            else if (sel == 1) addr = (($urandom_range(0, 1) == 0) ? 32'(4 * DEPTH) : ($urandom | 32'h8000_0000)) & 32'hFFFF_FFFC;
            else addr = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
            we = 1'($urandom); wdata = $urandom; be = 4'($urandom);
            t0 = txn_count;
            model_a(we, addr, wdata, be, erd, eerr);
            run_txn(we, addr, wdata, be, rd, err, lat);
            checks++;
            if (rd !== erd || err !== eerr || lat != WAITC + 1 || txn_count !== 16'(t0 + 16'd1)) begin
                failures++;
                $display("FAIL rand_%0d we=%b addr=%h got rd=%h err=%b lat=%0d txn=%0d exp rd=%h err=%b lat=%0d txn=%0d",
                         n, we, addr, rd, err, lat, txn_count, erd, eerr, WAITC + 1, t0 + 16'd1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$]; logic exp_e[$];
        logic [31:0] addr, wdata, erd; logic we, eerr;
        int nacc = 0, nrsp = 0, last_acc = -100;
        rsp_ready0 = 1'b1;
        for (int c = 0; c < 80 && nrsp < 10; c++) begin
            @(negedge clk);
            if (rsp_valid0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_spurious got valid=1 exp=0");
                end else if (rsp_rdata0 !== exp_q[0] || rsp_err0 !== exp_e[0] || cyc - last_acc != 1) begin
                    failures++; $display("FAIL b2b_rsp_%0d got rd=%h err=%b lat=%0d exp rd=%h err=%b lat=1",
                                         nrsp, rsp_rdata0, rsp_err0, cyc - last_acc, exp_q[0], exp_e[0]);
                end
                if (exp_q.size() != 0) begin void'(exp_q.pop_front()); void'(exp_e.pop_front()); end
                nrsp++;
            end
            if (req_ready0 && nacc < 10) begin
                if (nacc < 4) begin we = 1'b1; addr = 32'(nacc * 4); end
                else if (nacc < 8) begin we = 1'b0; addr = 32'((nacc - 4) * 4); end
                else if (nacc == 8) begin we = 1'b0; addr = 32'h5; end
                else begin we = 1'b0; addr = 32'(4 * DEPTH0); end
                wdata = $urandom;
                model_b(we, addr, wdata, 4'hF, erd, eerr);
                exp_q.push_back(erd); exp_e.push_back(eerr);
                req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata; req_be0 = 4'hF;
                if (nacc > 0) begin
                    checks++;
                    if (cyc + 1 - last_acc != 3) begin
                        failures++; $display("FAIL b2b_spacing_%0d got=%0d exp=3", nacc, cyc + 1 - last_acc);
                    end
                end
                last_acc = cyc + 1;
                nacc++;
            end else if (req_ready0) begin
                req_valid0 = 1'b0;
            end
        end
        req_valid0 = 1'b0;
        checks++; if (nrsp != 10) begin failures++; $display("FAIL b2b_count got=%0d exp=10", nrsp); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_readback();
        test_partial();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
